// File: rtl/grid_pkg.sv
// Shared parameters and types for the MEM_GRID accumulate sequencer.
// DW is one memory word (PARALLELISM complex float32 samples), AW is the
// full MEM_GRID address, L is the accept-to-write-back latency in cycles.
package grid_pkg;

    localparam int COMPLEX               = 2;
    localparam int PRECISION             = 32;
    localparam int PARALLELISM           = 15;
    localparam int BRAM_PARALLELISM_BITS = 4;
    localparam int BRAM_DEPTH_BITS       = 10;
    localparam int RD_LAT                = 2;
    localparam int ADD_LAT               = 8;

    localparam int DW        = PARALLELISM * PRECISION * COMPLEX;
    localparam int AW        = BRAM_PARALLELISM_BITS + BRAM_DEPTH_BITS;
    localparam int L         = RD_LAT + ADD_LAT + 2;
    localparam int TRK_DEPTH = L - 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } grid_state_t;

endpackage

// File: rtl/mem_grid_inflight.sv
// In-flight request tracker: a TRK_DEPTH-stage shift register of
// {valid, addr} that advances every cycle, with request data kept only in
// the first RD_LAT stages (long enough to line up with the memory read).
// Ports:
//   clk, rst          clock, async active-low reset
//   push              load a new entry into the head this cycle
//   push_addr/data    head entry contents
//   cmp_addr          address compared against every valid stage
//   hit               cmp_addr matches a valid entry
//   busy              any entry valid
//   tail_valid/addr   last stage; drives the write-back next cycle
//   rd_data           request data at stage RD_LAT-1
module mem_grid_inflight
    import grid_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic [AW-1:0] cmp_addr,
    output logic          hit,
    output logic          busy,
    output logic          tail_valid,
    output logic [AW-1:0] tail_addr,
    output logic [DW-1:0] rd_data
);

    logic [TRK_DEPTH-1:0] vld;
    logic [AW-1:0]        addr_q [TRK_DEPTH];
    logic [DW-1:0]        data_q [RD_LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
            for (int i = 0; i < TRK_DEPTH; i++) addr_q[i] <= '0;
            for (int i = 0; i < RD_LAT; i++)    data_q[i] <= '0;
        end else begin
            vld       <= {vld[TRK_DEPTH-2:0], push};
            addr_q[0] <= push_addr;
            for (int i = 1; i < TRK_DEPTH; i++) addr_q[i] <= addr_q[i-1];
            data_q[0] <= push_data;
            for (int i = 1; i < RD_LAT; i++)    data_q[i] <= data_q[i-1];
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < TRK_DEPTH; i++) begin
            if (vld[i] && (addr_q[i] == cmp_addr)) hit = 1'b1;
        end
    end

    assign busy       = |vld;
    assign tail_valid = vld[TRK_DEPTH-1];
    assign tail_addr  = addr_q[TRK_DEPTH-1];
    assign rd_data    = data_q[RD_LAT-1];

endmodule

// File: rtl/mem_grid_acc_ctrl.sv
// Read-modify-write sequencer in front of MEM_GRID. Each accepted request
// reads the stored vector, feeds it with the request vector to an external
// pipelined complex-float adder, and writes the sum back L cycles after the
// handshake. Also runs a whole-grid zero-fill sweep on demand.
// Ports:
//   clk, rst                  clock, async active-low reset
//   s_valid/s_ready           request handshake (s_ready combinational)
//   s_addr, s_data            target address and vector to add
//   clr_start                 pulse: drain then zero the whole grid
//   clr_busy, clr_done        clear in progress / completion pulse
//   mem_addr/din/we, mem_dout MEM_GRID single port
//   add_a, add_b, add_sum     external adder operands and result
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_RUN   | accepting requests; write-backs take the port first
// ST_DRAIN | clear requested; waiting for in-flight write-backs
// ST_CLEAR | writing zero to every address, one per cycle
module mem_grid_acc_ctrl
    import grid_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [AW-1:0] s_addr,
    input  logic [DW-1:0] s_data,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          clr_done,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout,
    output logic [DW-1:0] add_a,
    output logic [DW-1:0] add_b,
    input  logic [DW-1:0] add_sum
);

    grid_state_t   state;
    logic [AW-1:0] clr_cnt;
    logic          accept;
    logic          hit;
    logic          trk_busy;
    logic          tail_valid;
    logic [AW-1:0] tail_addr;
    logic [DW-1:0] trk_data;

    // A tail entry means a write-back owns the port next cycle, so no read
    // can be issued alongside it. clr_busy covers the clr_done cycle, where
    // the state has already returned to RUN.
    assign s_ready = rst && (state == ST_RUN) && !clr_busy && !tail_valid && !hit;
    assign accept  = s_valid && s_ready;
    assign add_a   = mem_dout;

    mem_grid_inflight u_inflight (
        .clk        (clk),
        .rst        (rst),
        .push       (accept),
        .push_addr  (s_addr),
        .push_data  (s_data),
        .cmp_addr   (s_addr),
        .hit        (hit),
        .busy       (trk_busy),
        .tail_valid (tail_valid),
        .tail_addr  (tail_addr),
        .rd_data    (trk_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_RUN;
            clr_cnt  <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            add_b    <= '0;
        end else begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            clr_done <= 1'b0;
            add_b    <= trk_data;

            if (clr_done) clr_busy <= 1'b0;

            if (tail_valid) begin
                mem_we   <= 1'b1;
                mem_addr <= tail_addr;
                mem_din  <= add_sum;
            end else if (accept) begin
                mem_addr <= s_addr;
            end

            case (state)
                ST_RUN: begin
                    if (clr_start && !clr_busy) begin
                        state    <= ST_DRAIN;
                        clr_busy <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Nothing left in flight: first zero write goes out now.
                    if (!trk_busy) begin
                        state    <= ST_CLEAR;
                        mem_we   <= 1'b1;
                        mem_addr <= '0;
                        clr_cnt  <= {{(AW-1){1'b0}}, 1'b1};
                    end
                end
                ST_CLEAR: begin
                    mem_we   <= 1'b1;
                    mem_addr <= clr_cnt;
                    clr_cnt  <= clr_cnt + 1'b1;
                    if (&clr_cnt) begin
                        clr_done <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule
